// File: rtl/dif_pair_buf.sv
// Radix-2 DIF stage input commutator: buffers the first half of each N-sample
// block and presents (x[k], x[k+N/2]) to the butterfly as one L/R pair strobe.
module dif_pair_buf #(
    parameter int IN_W         = 10,
    parameter int STAGE        = 0,
    parameter int TOTAL_STAGES = 8
) (
    input  logic                   mclk,
    input  logic                   i_rst_n,
    input  logic                   i_init,
    input  logic                   i_vld,
    input  logic signed [IN_W-1:0] i_I,
    input  logic signed [IN_W-1:0] i_Q,
    output logic                   o_vld,
    output logic signed [IN_W-1:0] o_LI,
    output logic signed [IN_W-1:0] o_LQ,
    output logic signed [IN_W-1:0] o_RI,
    output logic signed [IN_W-1:0] o_RQ,
    output logic                   o_sop
);
    localparam int STAGE_FFT_LEN = 2**(TOTAL_STAGES-STAGE);
    localparam int HALF          = STAGE_FFT_LEN / 2;
    localparam int CW            = (STAGE_FFT_LEN > 2) ? $clog2(STAGE_FFT_LEN) : 1;
    localparam logic [CW-1:0] HALF_C = CW'(HALF);

    logic [CW-1:0]     cnt;
    logic              acc;
    logic              pair_ph;
    logic [2*IN_W-1:0] rd_data;

    assign acc     = i_vld & ~i_init;
    // N is a power of two, so cnt >= HALF is exactly the counter MSB
    assign pair_ph = cnt[CW-1];

    always_ff @(posedge mclk or negedge i_rst_n) begin
        if (!i_rst_n)    cnt <= '0;
        else if (i_init) cnt <= '0;
        else if (acc)    cnt <= cnt + 1'b1;
    end

    generate
        if (HALF == 1) begin : g_reg
            logic [2*IN_W-1:0] buf_q;
            always_ff @(posedge mclk)
                if (acc && !pair_ph) buf_q <= {i_I, i_Q};
            assign rd_data = buf_q;
        end else begin : g_mem
            localparam int AW = $clog2(HALF);
            logic [2*IN_W-1:0] mem [HALF];
            logic [AW-1:0]     addr;
            // low bits address both the fill write and the (cnt - HALF) read
            assign addr = cnt[AW-1:0];
            always_ff @(posedge mclk)
                if (acc && !pair_ph) mem[addr] <= {i_I, i_Q};
            assign rd_data = mem[addr];
        end
    endgenerate

    // stage 1: capture L from the buffer and R from the input
    logic              p1_vld;
    logic              p1_sop;
    logic [2*IN_W-1:0] p1_l;
    logic [2*IN_W-1:0] p1_r;

    always_ff @(posedge mclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            p1_vld <= 1'b0;
            p1_sop <= 1'b0;
            p1_l   <= '0;
            p1_r   <= '0;
        end else begin
            p1_vld <= acc & pair_ph;
            p1_sop <= acc & pair_ph & (cnt == HALF_C);
            if (acc && pair_ph) begin
                p1_l <= rd_data;
                p1_r <= {i_I, i_Q};
            end
        end
    end

    // stage 2: a flush here kills the pair in flight; data outputs hold
    always_ff @(posedge mclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_vld <= 1'b0;
            o_sop <= 1'b0;
            o_LI  <= '0;
            o_LQ  <= '0;
            o_RI  <= '0;
            o_RQ  <= '0;
        end else begin
            o_vld <= p1_vld & ~i_init;
            o_sop <= p1_sop & ~i_init;
            if (p1_vld && !i_init) begin
                {o_LI, o_LQ} <= p1_l;
                {o_RI, o_RQ} <= p1_r;
            end
        end
    end
endmodule

// File: tb/tb_dif_pair_buf.sv
// Scoreboard bench for dif_pair_buf: an N=8 instance and an N=2 instance,
// each with a reference model feeding an expected-pair queue.
module tb_dif_pair_buf;
    logic mclk = 1'b0;
    always #5 mclk = ~mclk;

    logic rst_n = 1'b1;
    logic init8 = 1'b0, vld8 = 1'b0, init2 = 1'b0, vld2 = 1'b0;
    logic signed [9:0] I8 = '0, Q8 = '0, I2 = '0, Q2 = '0;
    logic ov8, os8, ov2, os2;
    logic signed [9:0] LI8, LQ8, RI8, RQ8, LI2, LQ2, RI2, RQ2;

    dif_pair_buf #(.IN_W(10), .STAGE(0), .TOTAL_STAGES(3)) dut8 (
        .mclk(mclk), .i_rst_n(rst_n), .i_init(init8), .i_vld(vld8),
        .i_I(I8), .i_Q(Q8), .o_vld(ov8), .o_LI(LI8), .o_LQ(LQ8),
        .o_RI(RI8), .o_RQ(RQ8), .o_sop(os8));

    dif_pair_buf #(.IN_W(10), .STAGE(7), .TOTAL_STAGES(8)) dut2 (
        .mclk(mclk), .i_rst_n(rst_n), .i_init(init2), .i_vld(vld2),
        .i_I(I2), .i_Q(Q2), .o_vld(ov2), .o_LI(LI2), .o_LQ(LQ2),
        .o_RI(RI2), .o_RQ(RQ2), .o_sop(os2));

    typedef struct {
        logic signed [9:0] li, lq, ri, rq;
        logic              sop;
        int                due;
    } pair_t;

    pair_t q8[$];
    pair_t q2[$];
    int checks = 0, errors = 0;
    int cyc = 0;
    int mcnt[2];
    int half_of[2];
    logic signed [9:0] mbI[2][4];
    logic signed [9:0] mbQ[2][4];
    logic signed [9:0] last_li8 = '0;

    always @(posedge mclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // drive one accepted sample and advance the reference model
    task automatic send(input int sel, input int vi, input int vq);
        logic signed [9:0] si, sq;
        pair_t p;
        int h;
        si = vi[9:0];
        sq = vq[9:0];
        if (sel == 0) begin vld8 = 1'b1; I8 = si; Q8 = sq; end
        else          begin vld2 = 1'b1; I2 = si; Q2 = sq; end
        @(posedge mclk); #1;
        vld8 = 1'b0; vld2 = 1'b0;
        h = half_of[sel];
        if (mcnt[sel] < h) begin
            mbI[sel][mcnt[sel]] = si;
            mbQ[sel][mcnt[sel]] = sq;
        end else begin
            p.li  = mbI[sel][mcnt[sel]-h];
            p.lq  = mbQ[sel][mcnt[sel]-h];
            p.ri  = si;
            p.rq  = sq;
            p.sop = (mcnt[sel] == h);
            p.due = cyc + 1;
            if (sel == 0) q8.push_back(p); else q2.push_back(p);
        end
        mcnt[sel] = (mcnt[sel] + 1) % (2*h);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge mclk); #1; end
    endtask

    // flush on the N=8 instance with a valid sample that must be dropped
    task automatic flush8(input int val);
        init8 = 1'b1; vld8 = 1'b1; I8 = val[9:0]; Q8 = val[9:0];
        @(posedge mclk); #1;
        init8 = 1'b0; vld8 = 1'b0;
        mcnt[0] = 0;
        for (int i = q8.size()-1; i >= 0; i--)
            if (q8[i].due == cyc) q8.delete(i);
        chk("flush_vld", ov8, 0);
        chk("flush_sop", os8, 0);
        chk("flush_hold_LI", LI8, last_li8);
    endtask

    task automatic drain();
        idle(4);
        chk("drain8", q8.size(), 0);
        chk("drain2", q2.size(), 0);
    endtask

    always @(negedge mclk) begin : mon8
        pair_t p;
        if (rst_n) begin
            if (ov8) begin
                if (q8.size() == 0) chk("unexpected8", 1, 0);
                else begin
                    p = q8.pop_front();
                    chk("LI8", LI8, p.li);
                    chk("LQ8", LQ8, p.lq);
                    chk("RI8", RI8, p.ri);
                    chk("RQ8", RQ8, p.rq);
                    chk("sop8", os8, p.sop);
                    chk("lat8", cyc, p.due);
                    last_li8 = p.li;
                end
            end else if (os8) chk("sop8_alone", os8, 0);
        end
    end

    always @(negedge mclk) begin : mon2
        pair_t p;
        if (rst_n) begin
            if (ov2) begin
                if (q2.size() == 0) chk("unexpected2", 1, 0);
                else begin
                    p = q2.pop_front();
                    chk("LI2", LI2, p.li);
                    chk("LQ2", LQ2, p.lq);
                    chk("RI2", RI2, p.ri);
                    chk("RQ2", RQ2, p.rq);
                    chk("sop2", os2, p.sop);
                    chk("lat2", cyc, p.due);
                end
            end else if (os2) chk("sop2_alone", os2, 0);
        end
    end

    initial begin
        half_of[0] = 4; half_of[1] = 1;
        mcnt[0] = 0;    mcnt[1] = 0;
        #1 rst_n = 1'b0;
        #11;
        chk("rst_vld", ov8, 0);
        chk("rst_sop", os8, 0);
        chk("rst_LI", LI8, 0);
        chk("rst_RQ", RQ8, 0);
        chk("rst_vld2", ov2, 0);
        @(negedge mclk); rst_n = 1'b1;

        // full-rate ramp
        for (int n = 0; n < 8; n++) send(0, n, -n);
        drain();

        // gapped ramp with a 5-cycle hole in the pair phase
        for (int n = 0; n < 8; n++) begin
            send(0, n, -n);
            idle((n == 5) ? 5 : 1);
        end
        drain();

        // three back-to-back blocks
        for (int n = 0; n < 24; n++) send(0, n, -n);
        drain();

        // mid-block flush after the first two pairs
        for (int n = 0; n < 6; n++) send(0, n, -n);
        idle(2);
        flush8(99);
        for (int n = 100; n < 108; n++) send(0, n, -n);
        drain();

        // flush right behind an R sample suppresses that pair
        for (int n = 0; n < 5; n++) send(0, n, -n);
        flush8(77);
        for (int n = 0; n < 8; n++) send(0, n, -n);
        drain();

        // async reset between edges in the pair phase
        for (int n = 0; n < 6; n++) send(0, n, -n);
        @(negedge mclk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld", ov8, 0);
        chk("arst_sop", os8, 0);
        chk("arst_LI", LI8, 0);
        chk("arst_LQ", LQ8, 0);
        chk("arst_RI", RI8, 0);
        chk("arst_RQ", RQ8, 0);
        q8.delete();
        mcnt[0] = 0;
        @(posedge mclk);
        @(negedge mclk) rst_n = 1'b1;
        for (int n = 0; n < 8; n++) send(0, n, -n);
        drain();

        // N=2 stage with sign extremes
        send(1, 511, -512);
        send(1, -512, 511);
        send(1, -1, 0);
        send(1, 0, -1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
